// File: rtl/mux_tree_pipe_pkg.sv
// Shared helpers for the pipelined mux tree: stage count and stage-boundary placement.
package mux_tree_pipe_pkg;

    // Integer ceiling division, used to size the pipeline.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Number of register stages for a tree of sel_w levels, pipe_every levels per stage.
    function automatic int num_stages(input int sel_w, input int pipe_every);
        return ceil_div(sel_w, pipe_every);
    endfunction

    // True when a register stage follows tree level 'level'. The last level always
    // ends a stage so the output is registered.
    function automatic bit is_stage_end(input int level, input int sel_w, input int pipe_every);
        return (((level + 1) % pipe_every) == 0) || (level == sel_w - 1);
    endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Valid/ready bus of the pipelined mux: packed input words plus select in, one word out.
interface mux_tree_pipe_if #(
    parameter int WIDTH = 2,
    parameter int SEL_W = 5,
    parameter int N_IN  = 32
);
    logic [N_IN*WIDTH-1:0] in_flat;
    logic [SEL_W-1:0]      select;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_err;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_flat, select, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  in_flat, select, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid
    );
endinterface

// File: rtl/mux_tree_pipe_level.sv
// One level of the mux tree: N_PAIRS 2:1 muxes sharing a single select bit.
// Pair j takes words 2j (select 0) and 2j+1 (select 1) of the packed input bus.
module mux_tree_pipe_level #(
    parameter int WIDTH   = 2,
    parameter int N_PAIRS = 1
) (
    input  logic [2*N_PAIRS*WIDTH-1:0] i_data,
    input  logic                       i_sel,
    output logic [N_PAIRS*WIDTH-1:0]   o_data
);

    // Halve the word count by picking one word of each adjacent pair.
    always_comb begin
        o_data = '0;
        for (int j = 0; j < N_PAIRS; j++) begin
            o_data[j*WIDTH +: WIDTH] = i_sel ? i_data[(2*j+1)*WIDTH +: WIDTH]
                                             : i_data[(2*j)*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N-to-1 mux. A binary tree of SEL_W 2:1 levels resolves the select LSB
// first; a register stage follows every PIPE_EVERY levels and the last level.
// Each stage carries its surviving words, the still-unresolved select bits, the
// out-of-range flag and a valid bit. Stages compress bubbles under backpressure.
module mux_tree_pipe
    import mux_tree_pipe_pkg::*;
#(
    parameter int               WIDTH       = 2,
    parameter int               SEL_W       = 5,
    parameter int               N_IN        = 32,
    parameter int               PIPE_EVERY  = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic            clock,
    input  logic            reset,
    mux_tree_pipe_if.slave  bus
);

    localparam int S       = num_stages(SEL_W, PIPE_EVERY);
    localparam int N_SLOTS = 2 ** SEL_W;

    if ((N_IN < 2) || (N_IN > N_SLOTS)) begin : g_chk_n_in
        $error("mux_tree_pipe: N_IN must satisfy 2 <= N_IN <= 2**SEL_W");
    end
    if (PIPE_EVERY < 1) begin : g_chk_pipe
        $error("mux_tree_pipe: PIPE_EVERY must be at least 1");
    end

    logic [S-1:0]             r_vld;
    logic [S-1:0]             w_adv;
    logic [S-1:0]             w_vld_up;
    logic                     w_err_in;
    logic [N_SLOTS*WIDTH-1:0] w_din0;

    // Out-of-range selects are flagged here and travel with the word.
    assign w_err_in = ({1'b0, bus.select} >= (SEL_W+1)'(N_IN));

    // Unpopulated slots read as the default word.
    if (N_IN < N_SLOTS) begin : g_pad
        assign w_din0 = {{(N_SLOTS-N_IN){DEFAULT_VAL}}, bus.in_flat};
    end else begin : g_nopad
        assign w_din0 = bus.in_flat;
    end

    // Stage s may load when it or any stage below it is empty, or the output drains.
    for (genvar s = 0; s < S; s++) begin : g_stg
        assign w_adv[s] = bus.out_ready || !(&r_vld[S-1:s]);
        if (s == 0) begin : g_head
            assign w_vld_up[s] = bus.in_valid;
        end else begin : g_body
            assign w_vld_up[s] = r_vld[s-1];
        end
    end

    // Valid bits: the only state that must be cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
        end else begin
            for (int s = 0; s < S; s++) begin
                if (w_adv[s]) r_vld[s] <= w_vld_up[s];
            end
        end
    end

    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = r_vld[S-1];

    for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
        localparam int IN_W  = 2 ** (SEL_W - k);
        localparam int OUT_W = IN_W / 2;
        localparam int SW    = SEL_W - k;

        logic [IN_W*WIDTH-1:0]  w_din;
        logic [SW-1:0]          w_sel;
        logic                   w_err;
        logic [OUT_W*WIDTH-1:0] w_dout;

        if (k == 0) begin : g_src
            assign w_din = w_din0;
            assign w_sel = bus.select;
            assign w_err = w_err_in;
        end else begin : g_src
            assign w_din = g_lvl[k-1].g_fwd.w_nxt_data;
            assign w_sel = g_lvl[k-1].g_fwd.w_nxt_sel;
            assign w_err = g_lvl[k-1].g_fwd.w_nxt_err;
        end

        mux_tree_pipe_level #(
            .WIDTH   (WIDTH),
            .N_PAIRS (OUT_W)
        ) u_level (
            .i_data (w_din),
            .i_sel  (w_sel[0]),
            .o_data (w_dout)
        );

        if (k == SEL_W - 1) begin : g_out
            // ---- final stage boundary: output register ----
            logic [WIDTH-1:0] r_data;
            logic             r_err;

            // Output stage: substitute the default word for out-of-range selects.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_data <= '0;
                    r_err  <= 1'b0;
                end else if (w_adv[S-1]) begin
                    r_data <= w_err ? DEFAULT_VAL : w_dout;
                    r_err  <= w_err;
                end
            end

            assign bus.out_data = r_data;
            assign bus.out_err  = r_err;
        end else begin : g_fwd
            logic [OUT_W*WIDTH-1:0] w_nxt_data;
            logic [SW-2:0]          w_nxt_sel;
            logic                   w_nxt_err;

            if (is_stage_end(k, SEL_W, PIPE_EVERY)) begin : g_reg
                // ---- intermediate stage boundary ----
                logic [OUT_W*WIDTH-1:0] r_data;
                logic [SW-2:0]          r_sel;
                logic                   r_err;

                // Data-path stage register; contents are don't-care while invalid.
                always_ff @(posedge clock) begin
                    if (w_adv[k / PIPE_EVERY]) begin
                        r_data <= w_dout;
                        r_sel  <= w_sel[SW-1:1];
                        r_err  <= w_err;
                    end
                end

                assign w_nxt_data = r_data;
                assign w_nxt_sel  = r_sel;
                assign w_nxt_err  = r_err;
            end else begin : g_comb
                assign w_nxt_data = w_dout;
                assign w_nxt_sel  = w_sel[SW-1:1];
                assign w_nxt_err  = w_err;
            end
        end
    end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: four configurations, scoreboard queues per instance.
module tb_mux_tree_pipe;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    localparam logic [1:0] DEF_B = 2'b10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_c = 0, del_c = 0, acc_d = 0, del_d = 0;
    bit   lat_a = 1'b0;
    exp_t qa[$], qb[$], qc[$], qd[$];

    mux_tree_pipe_if #(.WIDTH(2),  .SEL_W(5), .N_IN(32)) ifa ();
    mux_tree_pipe_if #(.WIDTH(2),  .SEL_W(5), .N_IN(20)) ifb ();
    mux_tree_pipe_if #(.WIDTH(32), .SEL_W(3), .N_IN(8))  ifc ();
    mux_tree_pipe_if #(.WIDTH(32), .SEL_W(3), .N_IN(8))  ifd ();

    mux_tree_pipe #(.WIDTH(2), .SEL_W(5), .N_IN(32), .PIPE_EVERY(2), .DEFAULT_VAL(2'b00))
        u_a (.clock(clk), .reset(rst_n), .bus(ifa));
    mux_tree_pipe #(.WIDTH(2), .SEL_W(5), .N_IN(20), .PIPE_EVERY(2), .DEFAULT_VAL(DEF_B))
        u_b (.clock(clk), .reset(rst_n), .bus(ifb));
    mux_tree_pipe #(.WIDTH(32), .SEL_W(3), .N_IN(8), .PIPE_EVERY(1), .DEFAULT_VAL(32'd0))
        u_c (.clock(clk), .reset(rst_n), .bus(ifc));
    mux_tree_pipe #(.WIDTH(32), .SEL_W(3), .N_IN(8), .PIPE_EVERY(4), .DEFAULT_VAL(32'd0))
        u_d (.clock(clk), .reset(rst_n), .bus(ifd));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n) begin
            if (ifa.in_valid && ifa.in_ready) begin
                e.data = 32'(ifa.in_flat[int'(ifa.select)*2 +: 2]);
                e.err  = 1'b0;
                e.cyc  = cyc;
                qa.push_back(e);
            end
            if (ifa.out_valid && ifa.out_ready) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_out", 32'(ifa.out_valid), 0);
                end else begin
                    e = qa.pop_front();
                    chk("a_data", 32'(ifa.out_data), e.data);
                    chk("a_err", 32'(ifa.out_err), 32'(e.err));
                    if (lat_a) chk("a_latency", cyc - e.cyc, 3);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n) begin
            if (ifb.in_valid && ifb.in_ready) begin
                if (int'(ifb.select) < 20) begin
                    e.data = 32'(ifb.in_flat[int'(ifb.select)*2 +: 2]);
                    e.err  = 1'b0;
                end else begin
                    e.data = 32'(DEF_B);
                    e.err  = 1'b1;
                end
                e.cyc = cyc;
                qb.push_back(e);
            end
            if (ifb.out_valid && ifb.out_ready) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_out", 32'(ifb.out_valid), 0);
                end else begin
                    e = qb.pop_front();
                    chk("b_data", 32'(ifb.out_data), e.data);
                    chk("b_err", 32'(ifb.out_err), 32'(e.err));
                    chk("b_latency", cyc - e.cyc, 3);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (rst_n) begin
            if (ifc.in_valid && ifc.in_ready) begin
                e.data = ifc.in_flat[int'(ifc.select)*32 +: 32];
                e.err  = 1'b0;
                e.cyc  = cyc;
                qc.push_back(e);
                acc_c++;
            end
            if (ifc.out_valid && ifc.out_ready) begin
                if (qc.size() == 0) begin
                    chk("c_unexpected_out", 32'(ifc.out_valid), 0);
                end else begin
                    e = qc.pop_front();
                    del_c++;
                    chk("c_data", ifc.out_data, e.data);
                    chk("c_err", 32'(ifc.out_err), 32'(e.err));
                    chk("c_latency", cyc - e.cyc, 3);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_d
        exp_t e;
        if (rst_n) begin
            if (ifd.in_valid && ifd.in_ready) begin
                e.data = ifd.in_flat[int'(ifd.select)*32 +: 32];
                e.err  = 1'b0;
                e.cyc  = cyc;
                qd.push_back(e);
                acc_d++;
            end
            if (ifd.out_valid && ifd.out_ready) begin
                if (qd.size() == 0) begin
                    chk("d_unexpected_out", 32'(ifd.out_valid), 0);
                end else begin
                    e = qd.pop_front();
                    del_d++;
                    chk("d_data", ifd.out_data, e.data);
                    chk("d_err", 32'(ifd.out_err), 32'(e.err));
                    chk("d_latency", cyc - e.cyc, 1);
                end
            end
        end
    end

    task automatic send_a(input logic [4:0] sel);
        int n;
        n = 0;
        ifa.select   = sel;
        ifa.in_valid = 1'b1;
        @(negedge clk);
        while (!ifa.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("a_send_accept", 32'(n < 100), 1);
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((qa.size() + qb.size() + qc.size() + qd.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 200), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin : stim
        int          sels_a[4];
        int          sels_b[5];
        logic [1:0]  d0;
        int          sent;
        logic        v;
        logic [2:0]  s;
        logic [31:0] w;

        sels_a = '{0, 5, 31, 18};
        sels_b = '{25, 19, 20, 0, 31};

        for (int i = 0; i < 32; i++) ifa.in_flat[i*2 +: 2] = 2'(i % 4);
        for (int i = 0; i < 20; i++) ifb.in_flat[i*2 +: 2] = 2'($urandom);
        ifc.in_flat = '0;
        ifd.in_flat = '0;
        ifa.select = '0; ifb.select = '0; ifc.select = '0; ifd.select = '0;
        ifa.in_valid = 1'b0; ifb.in_valid = 1'b0; ifc.in_valid = 1'b0; ifd.in_valid = 1'b0;
        ifa.out_ready = 1'b1; ifb.out_ready = 1'b1; ifc.out_ready = 1'b1; ifd.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_out_valid", 32'(ifa.out_valid), 0);
        chk("rst_a_out_data", 32'(ifa.out_data), 0);
        chk("rst_a_out_err", 32'(ifa.out_err), 0);
        chk("rst_b_out_valid", 32'(ifb.out_valid), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_a_in_ready", 32'(ifa.in_ready), 1);

        // Streaming on defaults: selects 0, 5, 31, 18 back to back
        lat_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifa.select   = 5'(sels_a[i]);
            ifa.in_valid = 1'b1;
            @(negedge clk);
            chk("stream_in_ready", 32'(ifa.in_ready), 1);
            @(posedge clk);
            #1;
        end
        ifa.in_valid = 1'b0;
        wait_drain("stream_drain");
        lat_a = 1'b0;

        // Out-of-range selects on N_IN = 20
        for (int i = 0; i < 5; i++) begin
            ifb.select   = 5'(sels_b[i]);
            ifb.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        ifb.in_valid = 1'b0;
        wait_drain("oor_drain");

        // Backpressure: five words with the output stalled
        ifa.out_ready = 1'b0;
        send_a(5'd4);
        send_a(5'd9);
        send_a(5'd14);
        chk("bp_in_ready_low", 32'(ifa.in_ready), 0);
        chk("bp_out_valid", 32'(ifa.out_valid), 1);
        d0 = ifa.out_data;
        chk("bp_head_word", 32'(d0), 0);
        fork
            begin
                send_a(5'd19);
                send_a(5'd24);
            end
            begin
                repeat (6) begin
                    @(negedge clk);
                    chk("bp_stall_data", 32'(ifa.out_data), 32'(d0));
                    chk("bp_stall_valid", 32'(ifa.out_valid), 1);
                    chk("bp_stall_in_ready", 32'(ifa.in_ready), 0);
                end
                @(posedge clk);
                #1;
                ifa.out_ready = 1'b1;
            end
        join
        wait_drain("bp_drain");

        // Bubble compression: second word fills the gap behind a stalled head
        ifa.out_ready = 1'b0;
        send_a(5'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        ifa.select   = 5'd2;
        ifa.in_valid = 1'b1;
        @(negedge clk);
        chk("bubble_in_ready", 32'(ifa.in_ready), 1);
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send_a(5'd3);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("bubble_full_in_ready", 32'(ifa.in_ready), 0);
        ifa.out_ready = 1'b1;
        wait_drain("bubble_drain");

        // Reset with three words in flight
        ifa.out_ready = 1'b0;
        send_a(5'd5);
        send_a(5'd6);
        send_a(5'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(ifa.out_valid), 0);
        chk("midrst_out_data", 32'(ifa.out_data), 0);
        chk("midrst_out_err", 32'(ifa.out_err), 0);
        qa.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ifa.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", 32'(ifa.in_ready), 1);
        repeat (10) begin
            @(negedge clk);
            chk("midrst_no_stale", 32'(ifa.out_valid), 0);
        end

        // Random sweep on the 8-input, 32-bit configurations (S = 3 and S = 1)
        sent = 0;
        while (sent < 1000) begin
            v = ($urandom_range(0, 3) != 0);
            s = 3'($urandom);
            for (int j = 0; j < 8; j++) begin
                w = $urandom;
                ifc.in_flat[j*32 +: 32] = w;
                ifd.in_flat[j*32 +: 32] = w;
            end
            ifc.select   = s;
            ifd.select   = s;
            ifc.in_valid = v;
            ifd.in_valid = v;
            @(posedge clk);
            #1;
            if (v) sent++;
        end
        ifc.in_valid = 1'b0;
        ifd.in_valid = 1'b0;
        wait_drain("sweep_drain");
        chk("sweep_c_accepted", acc_c, 1000);
        chk("sweep_c_delivered", del_c, 1000);
        chk("sweep_d_accepted", acc_d, 1000);
        chk("sweep_d_delivered", del_d, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
